// File: rtl/data_ram_resp.sv
// data_ram_resp: single-ported 32-bit word RAM behind a valid/ready request
// channel, with a fixed-latency registered response and one request in flight.
//
// state  | meaning
// IDLE   | ready for a request; req_ready high outside reset
// WAIT   | request accepted, counting down the remaining latency
// RESP   | response presented; held until resp_ready
module data_ram_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_range;
  logic                  w_err;
  logic                  w_store_ok;
  logic [ADDR_WIDTH-1:0] w_widx;

  // Request decode: word index, alignment and range checks.
  assign w_widx     = req_addr[ADDR_WIDTH+1:2];
  assign w_misalign = |req_addr[1:0];
  assign w_range    = |(req_addr >> (ADDR_WIDTH + 2));
  assign w_err      = w_misalign | w_range;
  assign w_accept   = req_valid & req_ready;
  assign w_store_ok = w_accept & req_we & ~w_err;

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // A zero count can only follow a corrupted load; leave rather than hang.
        if (r_cnt <= 3'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs; req_ready is masked in the reset cycle so nothing is accepted.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    req_ready  = (r_state == S_IDLE) & ~rst;
    resp_valid = (r_state == S_RESP);
  end

  // Latency down-counter: loaded on accept, decremented while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 3'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Response register: captured only at accept, so it stays stable in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_err   <= w_err;
      r_rdata <= (!req_we && !w_err) ? r_mem[w_widx] : 32'd0;
    end
  end

  // Byte-strobed store at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) begin
          r_mem[w_widx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Bench for data_ram_resp: three instances (LATENCY 2, 1, 7) checked each
// cycle against a time-based transaction model, plus directed literal checks.
module tb_data_ram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv    [3];
  logic        iwe   [3];
  logic        irr   [3];
  logic [31:0] iaddr [3];
  logic [31:0] iwd   [3];
  logic [3:0]  istrb [3];
  logic        ordy  [3];
  logic        ov    [3];
  logic        oerr  [3];
  logic [31:0] ord   [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      data_ram_resp #(
        .ADDR_WIDTH(10),
        .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 7))
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (iv[g]),
        .req_ready  (ordy[g]),
        .req_we     (iwe[g]),
        .req_addr   (iaddr[g]),
        .req_wstrb  (istrb[g]),
        .req_wdata  (iwd[g]),
        .resp_valid (ov[g]),
        .resp_ready (irr[g]),
        .resp_rdata (ord[g]),
        .resp_err   (oerr[g])
      );
    end
  endgenerate

  int n_assert = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  logic [31:0] mm   [3][1024];
  bit   [3:0]  mkn  [3][1024];
  bit          mbusy[3];
  longint      macc [3];
  logic [31:0] mrd  [3];
  bit          merr [3];
  bit          mrkn [3];
  longint      mcyc = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 7);
  endfunction

  // Response is due once LATENCY cycles have elapsed since the accept.
  function automatic bit mvalid(input int i);
    return mbusy[i] && (mcyc >= macc[i] + longint'(lat_of(i)) - 1);
  endfunction

  always @(posedge clk) begin
    int w;
    bit e;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mbusy[i] = 1'b0;
      end else if (mbusy[i]) begin
        if (mvalid(i) && irr[i]) mbusy[i] = 1'b0;
      end else if (iv[i]) begin
        w = int'(iaddr[i][11:2]);
        e = (iaddr[i][1:0] != 2'd0) || (iaddr[i][31:12] != 20'd0);
        if (iwe[i]) begin
          if (!e) begin
            for (int b = 0; b < 4; b++) begin
              if (istrb[i][b]) begin
                mm[i][w][8*b +: 8] = iwd[i][8*b +: 8];
                mkn[i][w][b] = 1'b1;
              end
            end
          end
          mrd[i]  = 32'd0;
          mrkn[i] = 1'b1;
        end else begin
          mrd[i]  = e ? 32'd0 : mm[i][w];
          mrkn[i] = e || (mkn[i][w] == 4'hF);
        end
        merr[i]  = e;
        mbusy[i] = 1'b1;
        macc[i]  = mcyc + 1;
      end
    end
    mcyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit v;
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        v = mvalid(i);
        chk($sformatf("ready[%0d]", i), {31'd0, ordy[i]}, {31'd0, !mbusy[i] && !rst});
        chk($sformatf("valid[%0d]", i), {31'd0, ov[i]}, {31'd0, v});
        if (v) begin
          chk($sformatf("err[%0d]", i), {31'd0, oerr[i]}, {31'd0, merr[i]});
          if (mrkn[i]) chk($sformatf("rdata[%0d]", i), ord[i], mrd[i]);
        end
      end
    end
  end

  // Accept and response-rise timestamps for the back-to-back instances.
  int ncyc = 0;
  int acc1[$], val1[$], acc2[$], val2[$];
  bit pv1 = 1'b0, pv2 = 1'b0;
  always @(negedge clk) begin
    ncyc++;
    if (iv[1] === 1'b1 && ordy[1] === 1'b1) acc1.push_back(ncyc);
    if (iv[2] === 1'b1 && ordy[2] === 1'b1) acc2.push_back(ncyc);
    if (ov[1] === 1'b1 && !pv1) val1.push_back(ncyc);
    if (ov[2] === 1'b1 && !pv2) val2.push_back(ncyc);
    pv1 = (ov[1] === 1'b1);
    pv2 = (ov[2] === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic garble0();
    iv[0]    = 1'b0;
    iwe[0]   = 1'($urandom);
    iaddr[0] = $urandom;
    istrb[0] = 4'($urandom);
    iwd[0]   = $urandom;
  endtask

  task automatic txn(input bit we, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd  = 32'd0;
    er  = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    iv[0] = 1'b1; iwe[0] = we; iaddr[0] = addr; istrb[0] = strb; iwd[0] = wd;
    irr[0] = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (ordy[0] === 1'b1) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'd1, 32'd0);
        return;
      end
    end
    @(posedge clk); #1;
    garble0();
    forever begin
      @(negedge clk);
      lat++;
      if (ov[0] === 1'b1) break;
      if (lat > 20) begin
        chk("resp_timeout", 32'd1, 32'd0);
        return;
      end
    end
    rd = ord[0];
    er = oerr[0];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, ov[0]}, 32'd1);
      chk("hold_rdata", ord[0], rd);
      chk("hold_err", {31'd0, oerr[0]}, {31'd0, er});
      chk("hold_ready", {31'd0, ordy[0]}, 32'd0);
    end
    @(posedge clk); #1;
    irr[0] = 1'b1;
    @(posedge clk); #1;
    irr[0] = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", {31'd0, ov[0]}, 32'd0);
    chk("post_hs_ready", {31'd0, ordy[0]}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; iwe[i] = 1'b0; iaddr[i] = 32'd0; istrb[i] = 4'd0; iwd[i] = 32'd0;
      irr[i] = (i != 0);
    end
    // A load presented during reset must not be taken.
    iv[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ordy[0]}, 32'd0);
    chk("rst_valid", {31'd0, ov[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    iv[0] = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'd0, ordy[0]}, 32'd1);
    chk("rel_valid", {31'd0, ov[0]}, 32'd0);
    chk("rel_rdata", ord[0], 32'd0);
    chk("rel_err", {31'd0, oerr[0]}, 32'd0);

    txn(1'b1, 32'h0, 4'hF, 32'h1234_5678, 0, rd, er, lat);
    chk("st0_err", {31'd0, er}, 32'd0);

    txn(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, rd, er, lat);
    chk("st10_lat", lat, 32'd2);
    chk("st10_rdata", rd, 32'd0);
    chk("st10_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
    chk("ld10_lat", lat, 32'd2);
    chk("ld10_rdata", rd, 32'hDEAD_BEEF);
    chk("ld10_err", {31'd0, er}, 32'd0);

    txn(1'b1, 32'h10, 4'b0010, 32'h0000_AA00, 0, rd, er, lat);
    txn(1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
    chk("ldpart_rdata", rd, 32'hDEAD_AAEF);

    txn(1'b0, 32'h13, 4'h0, 32'h0, 0, rd, er, lat);
    chk("ld13_err", {31'd0, er}, 32'd1);
    chk("ld13_rdata", rd, 32'd0);

    txn(1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 0, rd, er, lat);
    chk("st1000_err", {31'd0, er}, 32'd1);
    txn(1'b0, 32'h0, 4'h0, 32'h0, 0, rd, er, lat);
    chk("ld0_rdata", rd, 32'h1234_5678);
    chk("ld0_err", {31'd0, er}, 32'd0);

    txn(1'b0, 32'h10, 4'h0, 32'h0, 5, rd, er, lat);
    chk("hold_rd", rd, 32'hDEAD_AAEF);

    // Reset during WAIT after a store: response dropped, data kept.
    @(posedge clk); #1;
    iv[0] = 1'b1; iwe[0] = 1'b1; iaddr[0] = 32'h20; istrb[0] = 4'hF; iwd[0] = 32'hCAFE_F00D;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ordy[0] === 1'b1) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    iwe[0] = 1'b0;
    @(negedge clk);
    chk("wait_rst_ready", {31'd0, ordy[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    garble0();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("dropped_valid", {31'd0, ov[0]}, 32'd0);
    end
    txn(1'b0, 32'h20, 4'h0, 32'h0, 0, rd, er, lat);
    chk("ld20_rdata", rd, 32'hCAFE_F00D);

    // Back-to-back loads on the LATENCY=1 and LATENCY=7 instances.
    @(posedge clk); #1;
    for (int i = 1; i < 3; i++) begin
      iv[i] = 1'b1; iwe[i] = 1'b0; iaddr[i] = 32'h40;
    end
    repeat (40) @(posedge clk);
    #1;
    iv[1] = 1'b0;
    iv[2] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("b2b1_count", {31'd0, (acc1.size() >= 4 && val1.size() >= 3)}, 32'd1);
    chk("b2b7_count", {31'd0, (acc2.size() >= 4 && val2.size() >= 3)}, 32'd1);
    if (acc1.size() >= 4 && val1.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("b2b1_lat", val1[k] - acc1[k], 32'd1);
        chk("b2b1_ivl", acc1[k+1] - acc1[k], 32'd2);
      end
    end
    if (acc2.size() >= 4 && val2.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("b2b7_lat", val2[k] - acc2[k], 32'd7);
        chk("b2b7_ivl", acc2[k+1] - acc2[k], 32'd8);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_ram_resp.md
DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width; memory depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to response valid; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wstrb  input  4  byte enables for a store; bit i enables wdata[8i+7:8i].
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready.
REQ-017 On accept, error SHALL be flagged when req_addr[1:0] != 0 or req_addr[31:ADDR_WIDTH+2] != 0.
REQ-018 On accept of an error-free store, each word byte with its strobe set SHALL be written at that clock edge; unstrobed bytes are unchanged.
REQ-019 Errored stores SHALL NOT modify memory.
REQ-020 On accept of an error-free load, the word at req_addr[ADDR_WIDTH+1:2] SHALL be captured at that clock edge into the response register.
REQ-021 Accept with LATENCY = 1 SHALL go to RESP; otherwise it SHALL go to WAIT and load a down-counter with LATENCY-1.
REQ-022 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 1.
REQ-023 resp_valid SHALL be 1 exactly in RESP and SHALL rise LATENCY cycles after the accept edge.
REQ-024 While resp_valid = 1, resp_rdata and resp_err SHALL be held stable.
REQ-025 RESP SHALL go to IDLE on resp_ready = 1; otherwise it SHALL stay in RESP indefinitely.
REQ-026 The minimum issue interval SHALL be LATENCY+1 cycles, with one outstanding request at most.
REQ-027 req_* inputs outside the accept cycle SHALL be ignored.
REQ-028 A store followed by a load to the same word SHALL return the post-store data.

Reset
REQ-029 rst = 1 at a clock edge SHALL force IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready is 0 during the rst cycle and 1 on the first cycle after it.
REQ-030 Reset mid-operation (WAIT or RESP) SHALL drop the pending response without a response handshake; a store committed at accept SHALL persist.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 A request presented in the rst cycle SHALL NOT be accepted.

Verification
REQ-033 LATENCY=2: store addr 0x10, wstrb 4'hF, wdata 0xDEADBEEF, then load 0x10 -> resp_valid 2 cycles after each accept; load rdata 0xDEADBEEF, err 0.
REQ-034 Store 0x10 wstrb 4'b0010 wdata 0x0000AA00 over 0xDEADBEEF, then load -> rdata 0xDEADAAEF.
REQ-035 Load 0x13 -> err 1, rdata 0; store 0x00001000 with ADDR_WIDTH=10 -> err 1, and a later load of 0x0 is unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles -> resp_valid, rdata, err stable and req_ready 0 throughout; resp_ready=1 -> IDLE next cycle.
REQ-037 Assert rst during WAIT after a store -> resp_valid never rises; a later load returns the stored word.
REQ-038 LATENCY=1 and LATENCY=7 back-to-back loads with resp_ready tied to 1 -> accept-to-valid is 1 and 7 cycles, and the issue interval is 2 and 8 cycles.
